o_buft_bank: RTL and testbench
==============================

Name: o_buft_bank

Overview:
- Parametrised, multi-channel registered tristate output bank for the ICB bitstream test set; the successor to the single-bit O_BUFT testcase.
- Each channel registers its data and drives a group of O_BUFT primitives.
- A per-channel FSM inserts a programmable turn-on delay and a turn-off guard, so a shared pad bus never sees overlapping drivers.
- Sits between fabric logic and the IO ring; one O_BUFT per pad bit.

Parameters:
- CHANNELS, 4: number of independently enabled channels.
- WIDTH, 8: pad bits per channel.
- ON_DELAY, 2: cycles spent in ARM before driving (0 allowed).
- OFF_GUARD, 3: cycles spent in COOL after release, during which drive is forbidden (0 allowed).
- CNT_W, $clog2(max(ON_DELAY,OFF_GUARD)+1): delay counter width (derived; do not override).

Ports:
- clk  input  1  single clock for the whole block.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  CHANNELS*WIDTH  write data; channel c occupies bits [c*WIDTH +: WIDTH].
- din_we  input  CHANNELS  per-channel data register load strobe.
- oe_req  input  CHANNELS  per-channel level request to drive the pads.
- dout  output  CHANNELS*WIDTH  pad outputs, each bit from its own O_BUFT.
- oe_state  output  CHANNELS  1 while the channel is in DRIVE (pads enabled).
- busy  output  CHANNELS  1 while the channel is in ARM or COOL.

Behaviour:
- Reset (async assert, sync release):
  - Every channel goes to HIZ immediately.
  - Data registers clear to 0; oe_state=0; busy=0; all O_BUFT T=0 (Hi-Z).
  - Reset asserted mid-DRIVE tristates the pads with no clock edge needed.
- O_BUFT hookup: I = data_q bit, T = registered enable. T=1 drives; T=0 is Hi-Z.
- Data register:
  - Loads on a clk edge where din_we[c]=1, independent of FSM state, so preloading in HIZ or ARM is legal.
  - A write while in DRIVE appears on dout one cycle later.
- Per-channel FSM states: HIZ, ARM, DRIVE, COOL.
  - HIZ: oe_req=1 → ARM with cnt=ON_DELAY. If ON_DELAY=0 → DRIVE directly.
  - ARM: oe_req=0 → HIZ; the pads were never driven, so no COOL is entered. Otherwise cnt==0 → DRIVE; else cnt-1.
  - DRIVE: oe_req=0 → COOL with cnt=OFF_GUARD. If OFF_GUARD=0 → HIZ.
  - COOL: oe_req is ignored. When cnt==0 → HIZ (or ARM if oe_req=1 that cycle); else cnt-1.
- Latency:
  - oe_req rising, first sampled at edge n → T=1 after edge n+ON_DELAY+1.
  - oe_req falling, sampled at edge k → T=0 after edge k (one-cycle latency).
  - Minimum re-drive spacing after release: OFF_GUARD+ON_DELAY+2 edges.
- Output decode:
  - T and oe_state are registered decodes of state==DRIVE, so they are glitch-free.
  - busy = (state==ARM)||(state==COOL), also registered.
- Independence: channels have no interaction; simultaneous requests on all channels are allowed.
- Counter: saturating down-counter of width CNT_W; no wrap.

Decomposition:
- Package o_buft_bank_pkg holds:
  - state enum (HIZ=2'd0, ARM=2'd1, DRIVE=2'd2, COOL=2'd3);
  - a function computing CNT_W.
- Sub-module o_buft_chan (one channel): FSM, counter, data register, and WIDTH O_BUFT instances.
- Top instantiates it CHANNELS times with a generate loop.

Test Plan:
1. Reset with rst_n=0 mid-DRIVE on ch0 (data 8'hA5) → dout immediately Hi-Z, oe_state=0, busy=0; after release data_q=0.
2. ch1: din_we with 8'h3C, then oe_req=1 sampled at edge 10 (ON_DELAY=2) → busy=1 edges 10-12, T=1 and dout[15:8]=8'h3C after edge 13.
3. ch1 DRIVE, oe_req=0 at edge 20, re-asserted at edge 21 (OFF_GUARD=3) → Hi-Z after edge 20, COOL until edge 24, ARM, drive resumes after edge 27.
4. ch2: oe_req pulsed for 1 cycle (abort in ARM) → pads never driven, back to HIZ, busy for 1 cycle, no COOL.
5. Parameter sweep ON_DELAY=0, OFF_GUARD=0 → drive after 1 edge, release to HIZ after 1 edge, busy never asserted.
6. All 4 channels: staggered random oe_req/din_we for 10k cycles → scoreboard checks state sequence and dout per channel, no Z→drive transition inside OFF_GUARD+ON_DELAY+2 edges of the previous release.

Source files
------------

// File: rtl/o_buft_bank_pkg.sv
// -----------------------------------------------------------------------------
// o_buft_bank_pkg
// Shared definitions for the registered tristate output bank:
//   chan_state_e  - per-channel sequencing states
//   calc_cnt_w()  - width of the delay/guard down-counter
// -----------------------------------------------------------------------------
package o_buft_bank_pkg;

    typedef enum logic [1:0] {
        HIZ   = 2'd0,
        ARM   = 2'd1,
        DRIVE = 2'd2,
        COOL  = 2'd3
    } chan_state_e;

    // Wide enough to hold the larger of the two delays. The result is never
    // smaller than one bit, so a zero/zero configuration still gets a legal vector.
    function automatic int calc_cnt_w(input int on_delay, input int off_guard);
        int max_v;
        max_v = (on_delay > off_guard) ? on_delay : off_guard;
        if (max_v < 1) begin
            return 1;
        end
        return $clog2(max_v + 1);
    endfunction

endpackage : o_buft_bank_pkg

// File: rtl/o_buft_chan.sv
// -----------------------------------------------------------------------------
// o_buft_chan
// One channel of the tristate output bank: a data register, a sequencing FSM
// with a programmable turn-on delay and turn-off guard, and one O_BUFT per pad
// bit.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   din_i      data to load into the channel register
//   din_we_i   data register load strobe
//   oe_req_i   level request to drive the pads
//   dout_o     pad outputs (Hi-Z unless the channel is in DRIVE)
//   oe_state_o 1 while the pads are enabled
//   busy_o     1 while arming or cooling down
//
// State table
//   state | meaning
//   HIZ   | idle, pads tristated
//   ARM   | request seen, counting down ON_DELAY before driving
//   DRIVE | pads enabled with the registered data
//   COOL  | released, pads tristated for OFF_GUARD cycles; requests ignored
// -----------------------------------------------------------------------------
module o_buft_chan
    import o_buft_bank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ON_DELAY  = 2,
    parameter int OFF_GUARD = 3,
    parameter int CNT_W     = calc_cnt_w(ON_DELAY, OFF_GUARD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    input  logic             din_we_i,
    input  logic             oe_req_i,
    output wire  [WIDTH-1:0] dout_o,
    output logic             oe_state_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] ON_CNT  = CNT_W'(ON_DELAY);
    localparam logic [CNT_W-1:0] OFF_CNT = CNT_W'(OFF_GUARD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    chan_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q;
    logic              drive_q;
    logic              busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HIZ: begin
                if (oe_req_i) begin
                    if (ON_DELAY == 0) begin
                        state_d = DRIVE;
                    end else begin
                        state_d = ARM;
                        cnt_d   = ON_CNT;
                    end
                end
            end
            ARM: begin
                // Dropping the request while arming skips COOL: nothing was driven.
                if (!oe_req_i) begin
                    state_d = HIZ;
                end else if (cnt_q == '0) begin
                    state_d = DRIVE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DRIVE: begin
                if (!oe_req_i) begin
                    if (OFF_GUARD == 0) begin
                        state_d = HIZ;
                    end else begin
                        state_d = COOL;
                        cnt_d   = OFF_CNT;
                    end
                end
            end
            COOL: begin
                // Leaving the guard always passes through ARM, even with a zero
                // turn-on delay, so a re-drive is never squeezed in early.
                if (cnt_q == '0) begin
                    if (oe_req_i) begin
                        state_d = ARM;
                        cnt_d   = ON_CNT;
                    end else begin
                        state_d = HIZ;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = HIZ;
                cnt_d   = '0;
            end
        endcase
    end

    // Enables are decoded from the next state so they change on the same edge
    // as the state itself and come straight out of flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HIZ;
            cnt_q   <= '0;
            data_q  <= '0;
            drive_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (din_we_i) begin
                data_q <= din_i;
            end
            drive_q <= (state_d == DRIVE);
            busy_q  <= (state_d == ARM) || (state_d == COOL);
        end
    end

    // One O_BUFT per pad bit: I = data_q bit, T = drive_q (1 drives, 0 Hi-Z).
    for (genvar b = 0; b < WIDTH; b++) begin : g_obuft
        assign dout_o[b] = drive_q ? data_q[b] : 1'bz;
    end

    assign oe_state_o = drive_q;
    assign busy_o     = busy_q;

endmodule : o_buft_chan

// File: rtl/o_buft_bank.sv
// -----------------------------------------------------------------------------
// o_buft_bank
// Multi-channel registered tristate output bank placed between fabric logic
// and the IO ring. Each channel sequences its own pad group so a shared pad
// bus never sees two drivers overlap.
//
// Ports
//   clk       clock
//   rst_n     asynchronous active-low reset
//   din       write data, channel c at [c*WIDTH +: WIDTH]
//   din_we    per-channel data load strobe
//   oe_req    per-channel drive request (level)
//   dout      pad outputs, one O_BUFT per bit
//   oe_state  per-channel: pads enabled
//   busy      per-channel: arming or cooling down
// -----------------------------------------------------------------------------
module o_buft_bank
    import o_buft_bank_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 8,
    parameter int ON_DELAY  = 2,
    parameter int OFF_GUARD = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       din_we,
    input  logic [CHANNELS-1:0]       oe_req,
    output wire  [CHANNELS*WIDTH-1:0] dout,
    output logic [CHANNELS-1:0]       oe_state,
    output logic [CHANNELS-1:0]       busy
);

    localparam int CNT_W = calc_cnt_w(ON_DELAY, OFF_GUARD);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        o_buft_chan #(
            .WIDTH     (WIDTH),
            .ON_DELAY  (ON_DELAY),
            .OFF_GUARD (OFF_GUARD),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .din_i      (din[c*WIDTH +: WIDTH]),
            .din_we_i   (din_we[c]),
            .oe_req_i   (oe_req[c]),
            .dout_o     (dout[c*WIDTH +: WIDTH]),
            .oe_state_o (oe_state[c]),
            .busy_o     (busy[c])
        );
    end

endmodule : o_buft_bank

// File: tb/tb_o_buft_bank.sv
module tb_o_buft_bank;

    localparam int CH        = 4;
    localparam int W         = 8;
    localparam int OD_A      = 2;
    localparam int OG_A      = 3;
    localparam int OD_B      = 0;
    localparam int OG_B      = 0;
    localparam int MIN_GAP_A = OG_A + OD_A + 2;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic [CH*W-1:0] din    = '0;
    logic [CH-1:0]   din_we = '0;
    logic [CH-1:0]   oe_req = '0;

    wire  [CH*W-1:0] dout_a;
    wire  [CH*W-1:0] dout_b;
    logic [CH-1:0]   oe_a, busy_a, oe_b, busy_b;

    always #5 clk = ~clk;

    o_buft_bank #(.CHANNELS(CH), .WIDTH(W), .ON_DELAY(OD_A), .OFF_GUARD(OG_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .din_we(din_we), .oe_req(oe_req),
        .dout(dout_a), .oe_state(oe_a), .busy(busy_a)
    );

    o_buft_bank #(.CHANNELS(CH), .WIDTH(W), .ON_DELAY(OD_B), .OFF_GUARD(OG_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .din_we(din_we), .oe_req(oe_req),
        .dout(dout_b), .oe_state(oe_b), .busy(busy_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // A released pad group reads as Z in a 4-state simulator and as 0 in a
    // 2-state one; either is accepted, a driven 1 is not.
    task automatic check_hiz(input string name, input logic [W-1:0] v);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (v[i] === 1'b1) ok = 1'b0;
        end
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected Hi-Z", name, v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model. A channel turns its pads on once the request has
    // been held for a run of edges that starts no earlier than the end of
    // the previous release guard; a run of L samples is needed, where
    // L = ON_DELAY+2, or 1 for a zero delay starting from idle (2 if that
    // run starts exactly as the guard expires).
    // ---------------------------------------------------------------------
    bit              m_drv  [2][CH];
    bit              m_busy [2][CH];
    bit              m_fc   [2][CH];
    int              m_s    [2][CH];
    int              m_run  [2][CH];
    logic [W-1:0]    m_data [2][CH];
    int              ecount      = 0;
    int              reset_count = 0;
    int              md_od, md_og, md_len;
    logic            md_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reset_count++;
            for (int g = 0; g < 2; g++) begin
                for (int c = 0; c < CH; c++) begin
                    m_drv[g][c]  = 1'b0;
                    m_busy[g][c] = 1'b0;
                    m_fc[g][c]   = 1'b0;
                    m_s[g][c]    = 0;
                    m_run[g][c]  = -1;
                    m_data[g][c] = '0;
                end
            end
        end else begin
            ecount++;
            for (int g = 0; g < 2; g++) begin
                md_od = (g == 0) ? OD_A : OD_B;
                md_og = (g == 0) ? OG_A : OG_B;
                for (int c = 0; c < CH; c++) begin
                    md_r = oe_req[c];
                    if (din_we[c]) m_data[g][c] = din[c*W +: W];
                    if (m_drv[g][c]) begin
                        if (!md_r) begin
                            m_drv[g][c] = 1'b0;
                            m_s[g][c]   = ecount + md_og + 1;
                            m_fc[g][c]  = (md_og > 0);
                            m_run[g][c] = -1;
                        end
                    end else if (ecount >= m_s[g][c]) begin
                        if (md_r) begin
                            if (m_run[g][c] < 0) m_run[g][c] = ecount;
                            if (md_od > 0) md_len = md_od + 2;
                            else if (m_run[g][c] == m_s[g][c] && m_fc[g][c]) md_len = 2;
                            else md_len = 1;
                            if (ecount - m_run[g][c] + 1 >= md_len) begin
                                m_drv[g][c] = 1'b1;
                                m_run[g][c] = -1;
                            end
                        end else begin
                            m_run[g][c] = -1;
                        end
                    end
                    m_busy[g][c] = !m_drv[g][c] &&
                                   ((m_fc[g][c] && ecount < m_s[g][c]) || m_run[g][c] >= 0);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Per-cycle compare against the model, plus a re-drive spacing monitor
    // on the delayed configuration that looks only at the DUT outputs.
    // ---------------------------------------------------------------------
    bit           cmp_en  = 1'b0;
    int           rc_seen = 0;
    bit           prev_oe   [CH];
    int           last_fall [CH];
    logic         a_oe, a_busy;
    logic [W-1:0] a_dout;

    always @(negedge clk) begin
        if (reset_count != rc_seen) begin
            rc_seen = reset_count;
            for (int c = 0; c < CH; c++) begin
                prev_oe[c]   = 1'b0;
                last_fall[c] = -1;
            end
        end
        if (rst_n && cmp_en) begin
            for (int g = 0; g < 2; g++) begin
                for (int c = 0; c < CH; c++) begin
                    a_oe   = (g == 0) ? oe_a[c]   : oe_b[c];
                    a_busy = (g == 0) ? busy_a[c] : busy_b[c];
                    a_dout = (g == 0) ? dout_a[c*W +: W] : dout_b[c*W +: W];
                    check($sformatf("oe_state cfg%0d ch%0d edge%0d", g, c, ecount),
                          32'(a_oe), 32'(m_drv[g][c]));
                    check($sformatf("busy cfg%0d ch%0d edge%0d", g, c, ecount),
                          32'(a_busy), 32'(m_busy[g][c]));
                    if (m_drv[g][c])
                        check($sformatf("dout cfg%0d ch%0d edge%0d", g, c, ecount),
                              32'(a_dout), 32'(m_data[g][c]));
                    else
                        check_hiz($sformatf("dout_hiz cfg%0d ch%0d edge%0d", g, c, ecount), a_dout);
                    if (g == 0) begin
                        if (a_oe && !prev_oe[c] && last_fall[c] >= 0) begin
                            n_assert++;
                            if (ecount - last_fall[c] < MIN_GAP_A) begin
                                n_fail++;
                                $display("FAIL redrive_gap ch%0d: got %0d edges, required at least %0d",
                                         c, ecount - last_fall[c], MIN_GAP_A);
                            end
                        end
                        if (!a_oe && prev_oe[c]) last_fall[c] = ecount;
                        prev_oe[c] = a_oe;
                    end
                end
            end
        end
    end

    // Hand-computed sequences for the directed scenarios.
    bit exp_busy2 [4] = '{1, 1, 1, 0};
    bit exp_oe2   [4] = '{0, 0, 0, 1};
    bit exp_oe3a  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    bit exp_busy3 [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    bit exp_oe3b  [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
    bit exp_oe4b  [4] = '{1, 0, 0, 0};
    bit exp_busy4 [4] = '{1, 0, 0, 0};

    int hold [CH];

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Reset state.
        tick();
        check("reset oe_state", 32'(oe_a), 32'(0));
        check("reset busy", 32'(busy_a), 32'(0));
        for (int c = 0; c < CH; c++) check_hiz($sformatf("reset dout ch%0d", c), dout_a[c*W +: W]);

        // Reset asserted while channel 0 drives 8'hA5.
        din[7:0]  = 8'hA5;
        din_we[0] = 1'b1;
        oe_req[0] = 1'b1;
        tick();
        din_we[0] = 1'b0;
        repeat (3) tick();
        check("ch0 drive oe", 32'(oe_a[0]), 32'(1));
        check("ch0 drive data", 32'(dout_a[7:0]), 32'(8'hA5));
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async reset oe_state", 32'(oe_a), 32'(0));
        check("async reset busy", 32'(busy_a), 32'(0));
        check_hiz("async reset dout ch0", dout_a[7:0]);
        check("async reset oe_state cfg b", 32'(oe_b), 32'(0));
        oe_req[0] = 1'b0;
        #1 rst_n = 1'b1;
        repeat (2) tick();
        oe_req[0] = 1'b1;
        repeat (4) tick();
        check("post-reset ch0 oe", 32'(oe_a[0]), 32'(1));
        check("post-reset ch0 data cleared", 32'(dout_a[7:0]), 32'(0));
        oe_req[0] = 1'b0;
        repeat (5) tick();

        // Channel 1 turn-on latency.
        din[15:8] = 8'h3C;
        din_we[1] = 1'b1;
        tick();
        din_we[1] = 1'b0;
        oe_req[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("ch1 on busy step%0d", i), 32'(busy_a[1]), 32'(exp_busy2[i]));
            check($sformatf("ch1 on oe step%0d", i), 32'(oe_a[1]), 32'(exp_oe2[i]));
            check($sformatf("ch1 on oe cfg b step%0d", i), 32'(oe_b[1]), 32'(1));
            check($sformatf("ch1 on busy cfg b step%0d", i), 32'(busy_b[1]), 32'(0));
        end
        check("ch1 data", 32'(dout_a[15:8]), 32'(8'h3C));

        // Channel 1 release then immediate re-request.
        tick();
        oe_req[1] = 1'b0;
        tick();
        check("ch1 release oe", 32'(oe_a[1]), 32'(exp_oe3a[0]));
        check("ch1 release busy", 32'(busy_a[1]), 32'(exp_busy3[0]));
        check("ch1 release oe cfg b", 32'(oe_b[1]), 32'(exp_oe3b[0]));
        oe_req[1] = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("ch1 redrive oe step%0d", i), 32'(oe_a[1]), 32'(exp_oe3a[i]));
            check($sformatf("ch1 redrive busy step%0d", i), 32'(busy_a[1]), 32'(exp_busy3[i]));
            check($sformatf("ch1 redrive oe cfg b step%0d", i), 32'(oe_b[1]), 32'(exp_oe3b[i]));
        end
        check("ch1 redrive data", 32'(dout_a[15:8]), 32'(8'h3C));
        oe_req[1] = 1'b0;
        repeat (6) tick();

        // Channel 2 one-cycle pulse aborts in ARM.
        din[23:16] = 8'h5A;
        din_we[2]  = 1'b1;
        oe_req[2]  = 1'b1;
        tick();
        din_we[2] = 1'b0;
        oe_req[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            check($sformatf("ch2 abort busy step%0d", i), 32'(busy_a[2]), 32'(exp_busy4[i]));
            check($sformatf("ch2 abort oe step%0d", i), 32'(oe_a[2]), 32'(0));
            check_hiz($sformatf("ch2 abort dout step%0d", i), dout_a[23:16]);
            check($sformatf("ch2 pulse oe cfg b step%0d", i), 32'(oe_b[2]), 32'(exp_oe4b[i]));
        end

        // Random staggered traffic on all channels.
        for (int c = 0; c < CH; c++) hold[c] = 0;
        for (int n = 0; n < 10000; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    oe_req[c] = 1'($urandom_range(0, 1));
                    hold[c]   = int'($urandom_range(1, 14));
                end else begin
                    hold[c]--;
                end
                din_we[c]      = ($urandom_range(0, 3) == 0);
                din[c*W +: W]  = 8'($urandom);
            end
            tick();
        end
        oe_req = '0;
        din_we = '0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_o_buft_bank
